// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit and its queues.
//   INST_NOP          : instruction shown on inst_IF while nothing is buffered
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   QDEPTH_DEFAULT    : default in-flight + buffered capacity
//   QDEPTH_MAX        : largest supported capacity
//   CNT_W             : width of every occupancy / drop counter
//   fetch_entry_t     : one buffered instruction {pc, inst}
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          QDEPTH_DEFAULT   = 2;
  localparam int          QDEPTH_MAX       = 4;
  localparam int          CNT_W            = $clog2(QDEPTH_MAX + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO used for both the in-flight tag queue and the output
// instruction queue of fetch_unit.
//   clk, rst   : clock, synchronous active-high reset (control state only)
//   push       : write push_data (ignored when full unless popping too)
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the queue; wins over push/pop in the same cycle
//   head_data  : current head entry (valid when !empty)
//   count      : number of stored entries
//   empty      : count == 0
// Parameters: DEPTH (1..QDEPTH_MAX), DATA_W (entry width).
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: issues sequential word addresses to instruction
// memory, tracks in-flight requests, buffers in-order responses and presents
// them to the IF/ID register. Taken branches from ID redirect the fetch PC and
// discard every response still in flight.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   pc_en_if                      : hazard-unit enable (0 = stall, hold output)
//   branch_id, branch_target_id   : redirect request and target from ID
//   imem_req_valid/ready/addr     : instruction memory request channel
//   imem_rsp_valid/data           : in-order response channel, no backpressure
//   inst_valid_IF, inst_IF, pc_IF : instruction presented to IF/ID
//   perf_fetch_cnt, perf_bubble_cnt : only with FETCH_PERF_CNT_EN defined
// Parameters: RESET_PC, QDEPTH (1..4, in-flight + buffered capacity).
// Optional build macro: FETCH_PERF_CNT_EN adds the two performance counters.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = QDEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en_if,
  input  logic        branch_id,
  input  logic [31:0] branch_target_id,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid_IF,
  output logic [31:0] inst_IF,
  output logic [31:0] pc_IF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  if (QDEPTH < 1 || QDEPTH > QDEPTH_MAX) begin : g_bad_qdepth
    $error("fetch_unit: QDEPTH out of range 1..4");
  end

  localparam logic [CNT_W:0] QDEPTH_C = (CNT_W + 1)'(QDEPTH);

  logic               redirect;
  logic               issue;
  logic               rsp_pop;
  logic               rsp_drop;
  logic               rsp_vld_p0;
  logic               deq;
  logic [31:0]        pc_req;
  logic [31:0]        pc_hold;
  logic [31:0]        tag_head;
  logic [CNT_W-1:0]   tag_cnt;
  logic [CNT_W-1:0]   out_cnt;
  logic [CNT_W-1:0]   drop_cnt;
  logic [CNT_W:0]     occ;
  logic               tag_empty;
  logic               out_empty;
  fetch_entry_t       out_in;
  fetch_entry_t       out_head;

  // Stall has priority: a branch seen while pc_en_if=0 is ignored.
  assign redirect = branch_id && pc_en_if;
  assign occ      = {1'b0, tag_cnt} + {1'b0, out_cnt};

  // ---- issue stage: request address and in-flight tag queue ----
  assign imem_req_valid = !rst && (occ < QDEPTH_C) && !redirect;
  assign imem_req_addr  = pc_req;
  assign issue          = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst)           pc_req <= RESET_PC;
    else if (redirect) pc_req <= word_align(branch_target_id);
    else if (issue)    pc_req <= pc_req + 32'd4;
  end

  fetch_fifo #(
    .DEPTH  (QDEPTH),
    .DATA_W (32)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (pc_req),
    .pop       (rsp_pop),
    .flush     (1'b0),
    .head_data (tag_head),
    .count     (tag_cnt),
    .empty     (tag_empty)
  );

  // ---- response stage: pair data with its tag, or discard stale ones ----
  // A response landing in the redirect cycle is already counted as in flight,
  // so it is removed from the drop count as it is discarded here.
  assign rsp_pop    = imem_rsp_valid && !tag_empty;
  assign rsp_drop   = redirect || (drop_cnt != '0);
  assign rsp_vld_p0 = rsp_pop && !rsp_drop;
  assign out_in     = '{pc: tag_head, inst: imem_rsp_data};

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (redirect)
      drop_cnt <= tag_cnt - CNT_W'(rsp_pop);
    else if (rsp_pop && (drop_cnt != '0))
      drop_cnt <= drop_cnt - 1'b1;
  end

  // ---- output stage: registered instruction queue towards IF/ID ----
  assign deq = pc_en_if && !out_empty && !redirect;

  fetch_fifo #(
    .DEPTH  (QDEPTH),
    .DATA_W ($bits(fetch_entry_t))
  ) u_out_q (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_vld_p0),
    .push_data (out_in),
    .pop       (deq),
    .flush     (redirect),
    .head_data (out_head),
    .count     (out_cnt),
    .empty     (out_empty)
  );

  // pc_IF keeps showing the last presented address while the queue is empty.
  always_ff @(posedge clk) begin
    if (rst)             pc_hold <= RESET_PC;
    else if (!out_empty) pc_hold <= out_head.pc;
  end

  assign inst_valid_IF = !out_empty;
  assign inst_IF       = out_empty ? INST_NOP : out_head.inst;
  assign pc_IF         = out_empty ? pc_hold  : out_head.pc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (deq)                   perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (pc_en_if && out_empty) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A behavioural memory (in-order queue with
// programmable latency) answers requests; the expected instruction stream is
// the architectural one: consecutive word addresses, restarted at the aligned
// branch target whenever a redirect is taken.
// The unit is built with QDEPTH=3, the smallest capacity that keeps one
// instruction per cycle flowing with a 1-cycle memory plus the registered
// output queue.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          QD  = 3;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          N_CYC = 1500;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_en_if;
  logic        branch_id;
  logic [31:0] branch_target_id;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid_IF;
  logic [31:0] inst_IF;
  logic [31:0] pc_IF;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RPC),
    .QDEPTH   (QD)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_en_if         (pc_en_if),
    .branch_id        (branch_id),
    .branch_target_id (branch_target_id),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .inst_valid_IF    (inst_valid_IF),
    .inst_IF          (inst_IF),
    .pc_IF            (pc_IF)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_bubble_cnt  (perf_bubble_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc;
  int          lat;
  int          n_deq;
  int          wrap_cnt;
  logic        watch_req;
  logic        watch_pc;
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  logic [31:0] last_pc;
  logic        prev_stall;
  logic        prev_v;
  logic [31:0] prev_pc;
  logic [31:0] prev_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    pc_en_if         = 1'b1;
    branch_id        = 1'b0;
    imem_req_ready   = 1'b1;
    branch_target_id = $urandom;
    if (cyc < 40) begin
      lat = 1;
    end else if (cyc < 43) begin
      lat      = 1;
      pc_en_if = 1'b0;
    end else if (cyc < 100) begin
      lat = 3;
      if (cyc == 60) begin
        branch_id        = 1'b1;
        branch_target_id = 32'h0000_0103;
        watch_req        = 1'b1;
        watch_pc         = 1'b1;
      end
      if (cyc == 80 || cyc == 81) begin
        branch_id        = 1'b1;
        pc_en_if         = 1'b0;
        branch_target_id = 32'h0000_4000;
      end
    end else if (cyc < 130) begin
      lat = 1;
      if (cyc == 100) begin
        branch_id        = 1'b1;
        branch_target_id = 32'hFFFF_FFFC;
        wrap_cnt         = 2;
      end
    end else begin
      lat            = 3;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      pc_en_if       = ($urandom_range(0, 4) != 0);
      branch_id      = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic drive_rsp();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic observe();
    logic redir;
    logic hs;
    logic deq;
    redir = branch_id && pc_en_if;
    hs    = imem_req_valid && imem_req_ready;
    deq   = pc_en_if && inst_valid_IF && !redir;

    chk("inflight_le_qdepth", 32'(mem_q.size() <= QD), 32'd1);
    if (redir) chk("no_issue_on_redirect", 32'(imem_req_valid), 32'd0);

    if (!inst_valid_IF) begin
      chk("nop_when_empty", inst_IF, INST_NOP);
      chk("pc_hold_when_empty", pc_IF, last_pc);
    end else begin
      last_pc = pc_IF;
    end

    if (prev_stall && prev_v) begin
      chk("stall_valid_held", 32'(inst_valid_IF), 32'd1);
      chk("stall_pc_held", pc_IF, prev_pc);
      chk("stall_inst_held", inst_IF, prev_inst);
    end

    if (deq) begin
      chk("deq_pc", pc_IF, exp_pc);
      chk("deq_inst", inst_IF, mem_word(pc_IF));
      if (watch_pc) begin
        chk("redirect_first_pc", pc_IF, 32'h0000_0100);
        watch_pc = 1'b0;
      end
      exp_pc = exp_pc + 32'd4;
      n_deq++;
    end

    if (imem_rsp_valid) void'(mem_q.pop_front());

    if (hs) begin
      chk("req_addr", imem_req_addr, exp_req);
      if (watch_req) begin
        chk("redirect_first_req", imem_req_addr, 32'h0000_0100);
        watch_req = 1'b0;
      end
      if (wrap_cnt > 0) begin
        wrap_cnt--;
        if (wrap_cnt == 0) chk("wrap_req", imem_req_addr, 32'h0000_0000);
      end
      mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      exp_req = exp_req + 32'd4;
    end

    if (redir) begin
      exp_req = {branch_target_id[31:2], 2'b00};
      exp_pc  = exp_req;
    end

    prev_stall = !pc_en_if;
    prev_v     = inst_valid_IF;
    prev_pc    = pc_IF;
    prev_inst  = inst_IF;
  endtask

  initial begin
    rst              = 1'b1;
    pc_en_if         = 1'b1;
    branch_id        = 1'b0;
    branch_target_id = 32'h0;
    imem_req_ready   = 1'b1;
    imem_rsp_valid   = 1'b0;
    imem_rsp_data    = 32'h0;
    cyc              = 0;
    lat              = 1;
    n_deq            = 0;
    wrap_cnt         = 0;
    watch_req        = 1'b0;
    watch_pc         = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid_IF), 32'd0);
      chk("rst_inst_nop", inst_IF, INST_NOP);
      chk("rst_pc", pc_IF, RPC);
    end

    @(posedge clk);
    #1;
    rst        = 1'b0;
    mem_q.delete();
    exp_pc     = RPC;
    exp_req    = RPC;
    last_pc    = RPC;
    prev_stall = 1'b0;
    prev_v     = 1'b0;
    prev_pc    = RPC;
    prev_inst  = INST_NOP;

    for (cyc = 0; cyc < N_CYC; cyc++) begin
      drive_inputs();
      drive_rsp();
      @(negedge clk);
      if (cyc == 0) chk("req_valid_after_reset", 32'(imem_req_valid), 32'd1);
      if (cyc < 12) chk("startup_valid", 32'(inst_valid_IF), 32'(cyc >= 2));
      if (cyc == 41 || cyc == 42) chk("full_blocks_issue", 32'(imem_req_valid), 32'd0);
      observe();
      @(posedge clk);
      #1;
    end

    chk("progress", 32'(n_deq >= 200), 32'd1);
    chk("redirect_req_seen", 32'(watch_req), 32'd0);
    chk("redirect_pc_seen", 32'(watch_pc), 32'd0);
    chk("wrap_seen", 32'(wrap_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
